// File: rtl/instruction_fetch_controller.sv
// instruction_fetch_controller: fetches, pc-stamps and issues instructions to decode; define WATCHDOG_EN for the issue/wait watchdog
module instruction_fetch_controller #(
  parameter logic [4:0] RESET_PC    = 5'd0,
  parameter logic [4:0] HALT_OPCODE = 5'd31,
  parameter logic [7:0] TIMEOUT     = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_rd_en,
  output logic [4:0]  imem_addr,
  input  logic [58:0] imem_rdata,
  output logic        dec_start,
  output logic [58:0] dec_instruction,
  input  logic        dec_busy,
  input  logic        dec_done,
  input  logic        fetch_stage_enable,
  input  logic [4:0]  next_pc_from_dec,
  output logic [4:0]  pc,
  output logic        halted,
  output logic [15:0] instr_count,
  output logic        timeout_err
);
  typedef enum logic [2:0] {IDLE, FETCH, FETCH_WAIT, ISSUE, WAIT_DONE, HALT} state_t;
  state_t state, state_n;
  logic is_halt, complete, wd_hit;
  assign is_halt  = imem_rdata[56:52] == HALT_OPCODE;
  assign complete = dec_done && !dec_busy && fetch_stage_enable;
`ifdef WATCHDOG_EN
  logic [7:0] wd;
  logic       to_err;
  assign wd_hit = wd == TIMEOUT - 8'd1;
  // watchdog counts cycles of one ISSUE/WAIT_DONE visit; error is sticky until a new run
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wd     <= '0;
      to_err <= 1'b0;
    end else begin
      wd     <= (state_n == state && (state == ISSUE || state == WAIT_DONE)) ? wd + 8'd1 : '0;
      to_err <= (state == IDLE && run) ? 1'b0 :
                to_err | (state_n == HALT && (state == ISSUE || state == WAIT_DONE));
    end
  assign timeout_err = to_err;
`else
  assign wd_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif
  // next-state; a started instruction always runs to completion regardless of run
  always_comb begin
    state_n = state;
    case (state)
      IDLE:       state_n = run ? FETCH : IDLE;
      FETCH:      state_n = FETCH_WAIT;
      FETCH_WAIT: state_n = is_halt ? HALT : ISSUE;
      ISSUE:      state_n = dec_busy ? WAIT_DONE : wd_hit ? HALT : ISSUE;
      WAIT_DONE:  state_n = complete ? (run ? FETCH : IDLE) : wd_hit ? HALT : WAIT_DONE;
      HALT:       state_n = run ? HALT : IDLE;
      default:    state_n = IDLE;
    endcase
  end
  assign imem_rd_en = state == FETCH;
  assign imem_addr  = pc;
  assign dec_start  = state == ISSUE;
  assign halted     = state == HALT;
  // state, pc, issued word and completion counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state           <= IDLE;
      pc              <= RESET_PC;
      dec_instruction <= '0;
      instr_count     <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && run) begin
        pc          <= RESET_PC;
        instr_count <= '0;
      end
      if (state == FETCH_WAIT && !is_halt)
        dec_instruction <= {imem_rdata[58:37], pc, imem_rdata[31:0]};
      if (state == WAIT_DONE && complete) begin
        pc          <= next_pc_from_dec;
        instr_count <= instr_count + {15'd0, ~&instr_count};
      end
    end
endmodule
